// File: rtl/quantizer_1.sv
// ---------------------------------------------------------------------------
// quantizer_1 : JPEG luminance quantizer for one 8x8 block
//
// Every accepted start divides dct_in by the next entry of the standard JPEG
// luminance table (raster order) and rounds half away from zero. The result
// appears two edges after start is sampled, together with a one-cycle
// valid_out pulse.
//
// Ports
//   clk        in   1   system clock, rising edge
//   rst_n      in   1   asynchronous reset, active low
//   start      in   1   quantize dct_in with the current table entry
//   dct_in     in  16   signed DCT coefficient
//   quant_out  out 16   signed quantized coefficient (held between results)
//   valid_out  out  1   one-cycle pulse: quant_out holds a new result
//   done       out  1   set with the 64th result of a block, sticky
//   q_monitor  out  8   table value used for the result on quant_out
// ---------------------------------------------------------------------------
module quantizer_1 (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [15:0] dct_in,
  output logic [15:0] quant_out,
  output logic        valid_out,
  output logic        done,
  output logic [7:0]  q_monitor
);

  // Standard JPEG luminance quantization table, raster order.
  function automatic logic [7:0] q_lookup(input logic [5:0] idx);
    logic [7:0] q;
    case (idx)
      6'd0:  q = 8'd16;  6'd1:  q = 8'd11;  6'd2:  q = 8'd10;  6'd3:  q = 8'd16;
      6'd4:  q = 8'd24;  6'd5:  q = 8'd40;  6'd6:  q = 8'd51;  6'd7:  q = 8'd61;
      6'd8:  q = 8'd12;  6'd9:  q = 8'd12;  6'd10: q = 8'd14;  6'd11: q = 8'd19;
      6'd12: q = 8'd26;  6'd13: q = 8'd58;  6'd14: q = 8'd60;  6'd15: q = 8'd55;
      6'd16: q = 8'd14;  6'd17: q = 8'd13;  6'd18: q = 8'd16;  6'd19: q = 8'd24;
      6'd20: q = 8'd40;  6'd21: q = 8'd57;  6'd22: q = 8'd69;  6'd23: q = 8'd56;
      6'd24: q = 8'd14;  6'd25: q = 8'd17;  6'd26: q = 8'd22;  6'd27: q = 8'd29;
      6'd28: q = 8'd51;  6'd29: q = 8'd87;  6'd30: q = 8'd80;  6'd31: q = 8'd62;
      6'd32: q = 8'd18;  6'd33: q = 8'd22;  6'd34: q = 8'd37;  6'd35: q = 8'd56;
      6'd36: q = 8'd68;  6'd37: q = 8'd109; 6'd38: q = 8'd103; 6'd39: q = 8'd77;
      6'd40: q = 8'd24;  6'd41: q = 8'd35;  6'd42: q = 8'd55;  6'd43: q = 8'd64;
      6'd44: q = 8'd81;  6'd45: q = 8'd104; 6'd46: q = 8'd113; 6'd47: q = 8'd92;
      6'd48: q = 8'd49;  6'd49: q = 8'd64;  6'd50: q = 8'd78;  6'd51: q = 8'd87;
      6'd52: q = 8'd103; 6'd53: q = 8'd121; 6'd54: q = 8'd120; 6'd55: q = 8'd101;
      6'd56: q = 8'd72;  6'd57: q = 8'd92;  6'd58: q = 8'd95;  6'd59: q = 8'd98;
      6'd60: q = 8'd112; 6'd61: q = 8'd100; 6'd62: q = 8'd103; 6'd63: q = 8'd99;
      default: q = 8'd1;
    endcase
    return q;
  endfunction

  logic [5:0]  index_r;
  logic [5:0]  cur_idx_s;
  logic [16:0] x_ext_s;
  logic [16:0] mag_s;

  logic        s1_valid_r;
  logic        s1_neg_r;
  logic        s1_last_r;
  logic [16:0] s1_mag_r;
  logic [7:0]  s1_q_r;

  logic [16:0] sum_s;
  logic [16:0] divisor_s;
  logic [15:0] quo_s;

  logic        s2_valid_r;
  logic        s2_neg_r;
  logic        s2_last_r;
  logic [15:0] s2_quo_r;
  logic [7:0]  s2_q_r;

  // Capture-side combinational: table index and 17-bit input magnitude.
  always_comb begin
    cur_idx_s = index_r;
    if (done) begin
      // A start while done is high opens a new block at entry 0.
      cur_idx_s = 6'd0;
    end else begin
      cur_idx_s = index_r;
    end
    x_ext_s = {dct_in[15], dct_in};
    if (dct_in[15]) begin
      mag_s = 17'd0 - x_ext_s;
    end else begin
      mag_s = x_ext_s;
    end
  end

  // Table index: advances on each accepted start, wraps 63 -> 0 naturally.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      index_r <= 6'd0;
    end else if (start) begin
      index_r <= cur_idx_s + 6'd1;
    end
  end

  // Stage 1: latch sign, magnitude and table value of the accepted sample.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid_r <= 1'b0;
      s1_neg_r   <= 1'b0;
      s1_last_r  <= 1'b0;
      s1_mag_r   <= 17'd0;
      s1_q_r     <= 8'd0;
    end else begin
      s1_valid_r <= start;
      if (start) begin
        s1_neg_r  <= dct_in[15];
        s1_last_r <= (cur_idx_s == 6'd63);
        s1_mag_r  <= mag_s;
        s1_q_r    <= q_lookup(cur_idx_s);
      end
    end
  end

  // Rounded magnitude division: (|x| + floor(Q/2)) / Q. Divisor forced
  // non-zero while the stage is idle after reset.
  always_comb begin
    sum_s = s1_mag_r + {10'd0, s1_q_r[7:1]};
    if (s1_q_r == 8'd0) begin
      divisor_s = 17'd1;
    end else begin
      divisor_s = {9'd0, s1_q_r};
    end
    quo_s = 16'(sum_s / divisor_s);
  end

  // Stage 2: register the unsigned quotient.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s2_valid_r <= 1'b0;
      s2_neg_r   <= 1'b0;
      s2_last_r  <= 1'b0;
      s2_quo_r   <= 16'd0;
      s2_q_r     <= 8'd0;
    end else begin
      s2_valid_r <= s1_valid_r;
      if (s1_valid_r) begin
        s2_neg_r  <= s1_neg_r;
        s2_last_r <= s1_last_r;
        s2_quo_r  <= quo_s;
        s2_q_r    <= s1_q_r;
      end
    end
  end

  // Output stage: apply sign, hold result and Q between valid pulses.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      quant_out <= 16'd0;
      q_monitor <= 8'd0;
      valid_out <= 1'b0;
    end else begin
      valid_out <= s2_valid_r;
      if (s2_valid_r) begin
        quant_out <= s2_neg_r ? (16'd0 - s2_quo_r) : s2_quo_r;
        q_monitor <= s2_q_r;
      end
    end
  end

  // Block-complete flag: setting wins over a same-cycle start.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      done <= 1'b0;
    end else if (s2_valid_r && s2_last_r) begin
      done <= 1'b1;
    end else if (start && done) begin
      done <= 1'b0;
    end
  end

endmodule

// File: tb/tb_quantizer_1.sv
module tb_quantizer_1;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic [15:0] dct_in;
  logic [15:0] quant_out;
  logic        valid_out;
  logic        done;
  logic [7:0]  q_monitor;

  int n_cmp = 0;
  int n_err = 0;

  quantizer_1 dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .dct_in    (dct_in),
    .quant_out (quant_out),
    .valid_out (valid_out),
    .done      (done),
    .q_monitor (q_monitor)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit expired (got running, expected finished)");
    $fatal(1);
  end

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    start = 1'b0;
    dct_in = 16'd0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  // One start, then check no early pulse, the result, and the hold cycle.
  task automatic issue(input logic [15:0] x, input logic [15:0] exp_q,
                       input logic [7:0] exp_m, input string name);
    @(negedge clk);
    start = 1'b1;
    dct_in = x;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    n_cmp++;
    if (valid_out !== 1'b0) begin
      n_err++;
      $display("FAIL %s early_valid: got %b expected 0", name, valid_out);
    end
    @(negedge clk);
    n_cmp++;
    if (valid_out !== 1'b1 || quant_out !== exp_q || q_monitor !== exp_m) begin
      n_err++;
      $display("FAIL %s result: got v=%b q=%0d m=%0d expected v=1 q=%0d m=%0d",
               name, valid_out, $signed(quant_out), q_monitor, $signed(exp_q), exp_m);
    end
    @(negedge clk);
    n_cmp++;
    if (valid_out !== 1'b0 || quant_out !== exp_q || q_monitor !== exp_m) begin
      n_err++;
      $display("FAIL %s hold: got v=%b q=%0d m=%0d expected v=0 q=%0d m=%0d",
               name, valid_out, $signed(quant_out), q_monitor, $signed(exp_q), exp_m);
    end
  endtask

  task automatic test_reset();
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    n_cmp++;
    if (quant_out !== 16'd0 || valid_out !== 1'b0 || done !== 1'b0 || q_monitor !== 8'd0) begin
      n_err++;
      $display("FAIL reset_state: got q=%h v=%b d=%b m=%h expected all zero",
               quant_out, valid_out, done, q_monitor);
    end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_basic();
    issue(16'd100, 16'd6, 8'd16, "basic_pos");
    issue(-16'sd100, -16'sd9, 8'd11, "basic_neg");
  endtask

  task automatic test_rounding();
    do_reset();
    issue(16'd24, 16'd2, 8'd16, "round_24_q16");
    issue(-16'sd5, 16'd0, 8'd11, "round_m5_q11");
    issue(-16'sd15, -16'sd2, 8'd10, "round_tie_m15_q10");
  endtask

  task automatic test_extremes();
    do_reset();
    issue(16'h8000, -16'sd2048, 8'd16, "extreme_min");
    do_reset();
    issue(16'h7fff, 16'd2048, 8'd16, "extreme_max");
  endtask

  // 64 consecutive starts; start set at negedge c is sampled at the next
  // edge, so its result is visible at negedge c+3.
  task automatic test_back_to_back();
    int k;
    do_reset();
    for (int c = 0; c < 68; c++) begin
      @(negedge clk);
      k = c - 3;
      n_cmp++;
      if (valid_out !== ((c >= 3 && c <= 66) ? 1'b1 : 1'b0)) begin
        n_err++;
        $display("FAIL b2b_valid c=%0d: got %b", c, valid_out);
      end
      n_cmp++;
      if (done !== ((k >= 63) ? 1'b1 : 1'b0)) begin
        n_err++;
        $display("FAIL b2b_done c=%0d: got %b expected %b", c, done, (k >= 63));
      end
      if (k == 0) begin
        n_cmp++;
        if (quant_out !== 16'd63 || q_monitor !== 8'd16) begin
          n_err++;
          $display("FAIL b2b_first: got q=%0d m=%0d expected q=63 m=16", quant_out, q_monitor);
        end
      end
      if (k == 8) begin
        n_cmp++;
        if (quant_out !== 16'd83 || q_monitor !== 8'd12) begin
          n_err++;
          $display("FAIL b2b_idx8: got q=%0d m=%0d expected q=83 m=12", quant_out, q_monitor);
        end
      end
      if (k == 63) begin
        n_cmp++;
        if (quant_out !== 16'd10 || q_monitor !== 8'd99) begin
          n_err++;
          $display("FAIL b2b_last: got q=%0d m=%0d expected q=10 m=99", quant_out, q_monitor);
        end
      end
      start = (c < 64) ? 1'b1 : 1'b0;
      dct_in = 16'd1000;
    end
    start = 1'b0;
  endtask

  task automatic test_restart();
    @(negedge clk);
    n_cmp++;
    if (done !== 1'b1) begin
      n_err++;
      $display("FAIL restart_pre_done: got %b expected 1", done);
    end
    start = 1'b1;
    dct_in = 16'd160;
    @(negedge clk);
    start = 1'b0;
    n_cmp++;
    if (done !== 1'b0) begin
      n_err++;
      $display("FAIL restart_done_clear: got %b expected 0", done);
    end
    @(negedge clk);
    @(negedge clk);
    n_cmp++;
    if (valid_out !== 1'b1 || quant_out !== 16'd10 || q_monitor !== 8'd16 || done !== 1'b0) begin
      n_err++;
      $display("FAIL restart_result: got v=%b q=%0d m=%0d d=%b expected v=1 q=10 m=16 d=0",
               valid_out, quant_out, q_monitor, done);
    end
  endtask

  task automatic test_reset_mid();
    do_reset();
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      start = 1'b1;
      dct_in = 16'd200;
    end
    @(negedge clk);
    start = 1'b0;
    // Eighth result (index 7, Q=61) is on the outputs; two more in flight.
    n_cmp++;
    if (valid_out !== 1'b1 || quant_out !== 16'd3 || q_monitor !== 8'd61) begin
      n_err++;
      $display("FAIL mid_pre_reset: got v=%b q=%0d m=%0d expected v=1 q=3 m=61",
               valid_out, quant_out, q_monitor);
    end
    rst_n = 1'b0;
    #1;
    n_cmp++;
    if (quant_out !== 16'd0 || valid_out !== 1'b0 || done !== 1'b0 || q_monitor !== 8'd0) begin
      n_err++;
      $display("FAIL mid_reset_zero: got q=%h v=%b d=%b m=%h expected all zero",
               quant_out, valid_out, done, q_monitor);
    end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      n_cmp++;
      if (valid_out !== 1'b0 || quant_out !== 16'd0) begin
        n_err++;
        $display("FAIL mid_no_valid c=%0d: got v=%b q=%0d expected v=0 q=0", c, valid_out, quant_out);
      end
    end
    issue(16'd160, 16'd10, 8'd16, "mid_after_reset");
  endtask

  initial begin
    rst_n = 1'b0;
    start = 1'b0;
    dct_in = 16'd0;
    test_reset();
    test_basic();
    test_rounding();
    test_extremes();
    test_back_to_back();
    test_restart();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/quantizer_1.md
Name: quantizer_1

Overview:
JPEG quantization core for one 8x8 luminance block.
- Each start pulse quantizes the current dct_in sample against the next entry of a fixed 64-entry luminance table. The entries are taken in raster order.
- Emits a signed quotient with a valid_out pulse.
- Asserts done once all 64 coefficients of the block are produced.
- Sits behind the Wishbone register wrapper. The wrapper writes dct_in, pulses start, and reads quant_out, valid_out and done.

Parameters:
None. Table contents, block size (64) and data widths are fixed.

Ports:
clk  input  1  system clock, rising edge
rst_n  input  1  reset, active-low
start  input  1  one-cycle request: quantize dct_in with the current table entry
dct_in  input  16  signed DCT coefficient, two's complement
quant_out  output  16  signed quantized coefficient, two's complement
valid_out  output  1  one-cycle pulse: quant_out holds a new result
done  output  1  high once the 64th coefficient of the block has been output
q_monitor  output  8  table value Q used for the result currently on quant_out

Behaviour:
- Interface: one clock, clk; reset is asynchronous and active-low, rst_n.
- Reset values: quant_out=0, valid_out=0, done=0, q_monitor=0. Coefficient index = 0. Pipeline emptied.
- Table Q[0..63], standard JPEG luminance table (Annex K), raster order:
  16 11 10 16 24 40 51 61 / 12 12 14 19 26 58 60 55 / 14 13 16 24 40 57 69 56 / 14 17 22 29 51 87 80 62 / 18 22 37 56 68 109 103 77 / 24 35 55 64 81 104 113 92 / 49 64 78 87 103 121 120 101 / 72 92 95 98 112 100 103 99
- Index behaviour:
  - A 6-bit index selects Q.
  - Each cycle with start=1 captures dct_in and Q[index], then increments the index.
  - The index wraps from 63 to 0.
- Arithmetic:
  - quant_out = sign(x) * floor((|x| + floor(Q/2)) / Q), i.e. round-half-away-from-zero.
  - Use a 17-bit magnitude so that x = -32768 is exact.
  - Results always fit in 16 bits (|result| <= 3277).
  - Zero input gives 0, never -0 issues.
- Latency:
  - Fixed, fully pipelined.
  - If start is sampled high at edge N, quant_out, q_monitor and valid_out=1 update at edge N+2.
  - valid_out is high for exactly one cycle per accepted start.
  - start may be high on consecutive cycles; each accepted start yields one result, in order.
- Hold rule: quant_out and q_monitor hold their last value until the next result. Neither output changes when valid_out is low.
- done:
  - Set together with the valid_out of the coefficient taken at index 63.
  - Remains high until cleared.
  - Cleared on the cycle a start is accepted while done=1; that start begins a new block at index 0.
  - A start in the same cycle done is being set does not clear it.
- Reset mid-block: the asynchronous reset discards in-flight results and returns the index to 0. No valid_out is produced for discarded samples.
- start=0: no state change apart from pipeline advance.
- No error or overflow outputs.

Test Plan:
1. Reset, then start with dct_in=100 (index 0, Q=16) -> two cycles later valid_out pulses, quant_out=6, q_monitor=16. Next start with dct_in=-100 (index 1, Q=11) -> quant_out=-9, q_monitor=11.
2. Rounding ties, after reset: dct_in=24 at Q=16 -> 2. Then dct_in=-5 at Q=11 -> 0. Then dct_in=-15 at Q=10 -> -2 (tie rounds away from zero).
3. Extremes, after reset: dct_in=-32768 at Q=16 -> -2048. After re-reset, dct_in=32767 -> 2048.
4. Back-to-back: 64 consecutive start cycles with dct_in=1000 -> 64 valid_out pulses on consecutive cycles. The first result is 63 (1000/16) and the last is 10 (1000/99). done rises with the 64th pulse.
5. Block restart: with done=1, issue start with dct_in=160 -> done drops that cycle; result 10, q_monitor=16 (index wrapped to 0).
6. Reset mid-block: assert rst_n=0 after 10 starts with 2 results in flight -> outputs zero immediately, no further valid_out. The next start uses Q=16.
